// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ sources.
// One byte per grant, waits for tx_done (or watchdog abort), optional idle gap.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 timeout_err
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST =
        8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [WDW-1:0] wd;
    logic [7:0]     gap_cnt;

    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           found;
    int             s;

    // Search upward from the slot after the last winner, wrapping at NUM_REQ.
    always_comb begin
        win   = last_grant;
        idx   = '0;
        found = 1'b0;
        s     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            s = int'(last_grant) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = IDW'(s);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= IDW'(NUM_REQ - 1);
            wd          <= '0;
            gap_cnt     <= '0;
            req_ack     <= '0;
            req_done    <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ack     <= '0;
            req_done    <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        tx_start   <= 1'b1;
                        tx_data    <= req_data[8*win +: 8];
                        req_ack    <= NUM_REQ'(1) << win;
                        grant_id   <= win;
                        last_grant <= win;
                        wd         <= '0;
                        busy       <= 1'b1;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done || wd == WD_LAST) begin
                        if (tx_done) begin
                            req_done <= NUM_REQ'(1) << grant_id;
                        end else begin
                            timeout_err <= 1'b1;
                        end
                        gap_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter in two configurations
// (4 sources, no gap, 128-clock watchdog; 3 sources, 5-clock gap, 64-clock).
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cyc;
        logic [28:0] v;
    } ev_t;

    function automatic void check(string name, logic [31:0] got,
                                  logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [28:0] pk(logic st, logic [7:0] ack,
                                       logic [7:0] dn, logic to,
                                       logic [2:0] id, logic [7:0] dat);
        return {st, ack, dn, to, id, dat};
    endfunction

    localparam int NCYC = 12000;

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int N   = (g == 0) ? 4 : 3;
        localparam int GAP = (g == 0) ? 0 : 5;
        localparam int TMO = (g == 0) ? 128 : 64;
        localparam int IDW = $clog2(N);

        logic           reset;
        logic [N-1:0]   req;
        logic [8*N-1:0] req_data;
        logic [N-1:0]   req_ack;
        logic [N-1:0]   req_done;
        logic           tx_start;
        logic [7:0]     tx_data;
        logic           tx_done;
        logic           stub_done;
        logic           spur_done;
        logic           busy;
        logic [IDW-1:0] grant_id;
        logic           timeout_err;
        bit             done_f = 1'b0;
        int             cyc = 0;
        ev_t            sb[$];

        assign tx_done = stub_done | spur_done;

        always @(posedge clk) cyc <= cyc + 1;

        uart_tx_arbiter #(
            .NUM_REQ(N),
            .GAP_CYCLES(GAP),
            .TIMEOUT_CYCLES(TMO)
        ) dut (
            .clk(clk),
            .reset(reset),
            .req(req),
            .req_data(req_data),
            .req_ack(req_ack),
            .req_done(req_done),
            .tx_start(tx_start),
            .tx_data(tx_data),
            .tx_done(tx_done),
            .busy(busy),
            .grant_id(grant_id),
            .timeout_err(timeout_err)
        );

        function automatic logic [28:0] cur();
            return pk(tx_start, 8'(req_ack), 8'(req_done), timeout_err,
                      3'(grant_id), tx_data);
        endfunction

        // Monitor: any pulse must match the oldest expected event.
        initial begin : mon
            ev_t e;
            forever begin
                @(negedge clk);
                if (reset) continue;
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    check($sformatf("cfg%0d missing_event", g),
                          32'(cyc), 32'(sb[0].cyc));
                    void'(sb.pop_front());
                end
                if (tx_start || |req_ack || |req_done || timeout_err) begin
                    if (sb.size() == 0) begin
                        check($sformatf("cfg%0d unexpected_pulse", g),
                              32'(cur()), 32'(0));
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("cfg%0d event_cycle", g),
                              32'(cyc), 32'(e.cyc));
                        check($sformatf("cfg%0d event_value", g),
                              32'(cur()), 32'(e.v));
                    end
                end
            end
        end

        // Requesters, transmitter stub and frame-level reference model.
        initial begin : stim
            int          left[N];
            int          last, free_at, wait_end, start_c;
            int          stub_at, pend_d, w, r;
            logic [7:0]  last_data;
            bit          rst_done, cont, ending;

            reset     = 1'b1;
            req       = '0;
            req_data  = '0;
            stub_done = 1'b0;
            spur_done = 1'b0;
            for (int i = 0; i < N; i++) left[i] = 0;
            left[2] = 1;
            req_data[23:16] = 8'hA5;
            last = N - 1;
            stub_at = -1;
            pend_d = 0;
            w = 0;
            last_data = '0;
            rst_done = 1'b0;

            @(negedge clk);
            check($sformatf("cfg%0d reset_outputs", g),
                  32'({busy, cur()}), 32'(0));
            @(negedge clk);
            reset = 1'b0;
            free_at = cyc;
            wait_end = cyc;
            start_c = cyc;

            for (int k = 0; k < NCYC; k++) begin
                if (k > 0) @(negedge clk);
                cont   = (k >= 1000 && k < 4000);
                ending = (k >= NCYC - 300);

                if (!rst_done && k >= 6000 && cyc > start_c &&
                    cyc + 2 < wait_end) begin
                    #2 reset = 1'b1;
                    #1 check($sformatf("cfg%0d mid_reset_outputs", g),
                             32'({busy, cur()}), 32'(0));
                    sb.delete();
                    stub_at = -1;
                    stub_done = 1'b0;
                    spur_done = 1'b0;
                    repeat (2) @(negedge clk);
                    reset = 1'b0;
                    last = N - 1;
                    free_at = cyc;
                    wait_end = cyc;
                    start_c = cyc;
                    for (int i = 0; i < N; i++) begin
                        left[i] = 3;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                    rst_done = 1'b1;
                end

                check($sformatf("cfg%0d busy", g),
                      32'(busy), 32'(cyc < free_at));

                stub_done = 1'b0;
                spur_done = 1'b0;
                if (tx_start) stub_at = (pend_d > 0) ? cyc + pend_d : -1;
                if (cyc == stub_at) begin
                    stub_done = 1'b1;
                    stub_at = -1;
                end
                if (cyc >= wait_end && $urandom_range(0, 15) == 0)
                    spur_done = 1'b1;

                for (int i = 0; i < N; i++) begin
                    if (req_ack[i] && left[i] > 0) begin
                        left[i]--;
                        req_data[8*i +: 8] = 8'($urandom);
                    end else if (left[i] == 0 &&
                                 (cont || $urandom_range(0, 30) == 0)) begin
                        left[i] = cont ? 10 : $urandom_range(1, 3);
                        req_data[8*i +: 8] = 8'($urandom);
                    end else if (!cont && left[i] > 0 &&
                                 $urandom_range(0, 300) == 0) begin
                        left[i] = 0;
                    end
                    if (cont && left[i] == 0) left[i] = 10;
                    if (ending) left[i] = 0;
                    req[i] = (left[i] > 0);
                end

                if (cyc >= free_at && req != '0) begin
                    w = last;
                    for (int j = 1; j <= N; j++) begin
                        if (req[(last + j) % N]) begin
                            w = (last + j) % N;
                            break;
                        end
                    end
                    last = w;
                    last_data = req_data[8*w +: 8];
                    start_c = cyc + 1;
                    sb.push_back('{start_c,
                        pk(1'b1, 8'(1) << w, 8'h0, 1'b0, 3'(w), last_data)});
                    r = $urandom_range(0, 9);
                    if (r < 2) pend_d = 0;
                    else if (r == 2) pend_d = TMO - 1;
                    else if (r == 3) pend_d = 1;
                    else if (g == 0 && r < 7) pend_d = 100;
                    else pend_d = $urandom_range(2, TMO - 2);
                    if (pend_d > 0) begin
                        wait_end = start_c + pend_d + 1;
                        sb.push_back('{wait_end,
                            pk(1'b0, 8'h0, 8'(1) << w, 1'b0, 3'(w), last_data)});
                    end else begin
                        wait_end = start_c + TMO;
                        sb.push_back('{wait_end,
                            pk(1'b0, 8'h0, 8'h0, 1'b1, 3'(w), last_data)});
                    end
                    free_at = wait_end + GAP;
                end
            end

            @(negedge clk);
            check($sformatf("cfg%0d queue_drained", g),
                  32'(sb.size()), 32'(0));
            done_f = 1'b1;
        end
    end

    initial begin : top
        int t;
        t = 0;
        while (!(cfg[0].done_f && cfg[1].done_f) && t < 50000) begin
            @(negedge clk);
            t++;
        end
        check("bench_complete",
              32'(cfg[0].done_f && cfg[1].done_f), 32'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART byte transmitter between NUM_REQ independent byte sources.
- Sits between the requesters and the transmitter's start/tx_data/tx_done interface.
- Issues one byte per grant, waits for frame completion, and enforces an optional inter-frame gap.
- A watchdog recovers the arbiter if tx_done never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle clocks inserted after each completed or aborted frame before the next arbitration (0..255).
- TIMEOUT_CYCLES, 4096, clocks in WAIT_DONE without tx_done before abort (>=16).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester byte-pending level
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i]
- req_ack  out  NUM_REQ  1-cycle pulse: byte of requester i captured and sent to transmitter
- req_done  out  NUM_REQ  1-cycle pulse: frame of requester i completed (stop bit sent)
- tx_start  out  1  1-cycle start pulse to transmitter
- tx_data  out  8  byte to transmitter, valid in the tx_start cycle and held until next grant
- tx_done  in  1  1-cycle frame-complete pulse from transmitter
- busy  out  1  high in any state other than IDLE
- grant_id  out  max(1,clog2(NUM_REQ))  index of current/last granted requester
- timeout_err  out  1  1-cycle pulse when watchdog aborts a frame

Behaviour:
- Decided interface: reset is asynchronous, active-high; clock is clk.
- All outputs are registered.
- Reset values:
  - req_ack=0, req_done=0, tx_start=0, tx_data=0, busy=0, grant_id=0, timeout_err=0.
  - State=IDLE, timers=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, WAIT_DONE, GAP.
- IDLE:
  - If req!=0, the winner w is the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Next edge: tx_start=1, tx_data=req_data[w], req_ack[w]=1, grant_id=w, last_grant=w, watchdog=0, state=WAIT_DONE.
  - Latency from req assert to tx_start/req_ack is 1 clock. Pulses last exactly 1 clock.
  - If req=0, remain in IDLE with no pulses.
- WAIT_DONE:
  - Watchdog increments each clock. req changes are ignored.
  - On tx_done=1: req_done[grant_id]=1 for 1 clock next edge; go to GAP if GAP_CYCLES>0, else IDLE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without tx_done: timeout_err=1 for 1 clock, no req_done, and the same next-state rule applies.
  - If tx_done and timeout occur in the same cycle, tx_done wins: req_done, no error.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
  - Arbitration resumes in the IDLE cycle.
  - With GAP_CYCLES=0, tx_done at cycle t gives the next tx_start at t+2.
- tx_done seen in IDLE or GAP is ignored; no req_done.
- Requester rules:
  - Hold req and req_data stable until req_ack.
  - One req_ack equals one byte. To send another byte, keep req high after req_ack and present new data on the next cycle.
  - Dropping req before ack withdraws the request with no side effect.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 frames.
- Reset mid-operation: return to IDLE immediately and clear all pulses; any in-flight frame is not reported.
- grant_id and tx_data hold their values after a frame until the next grant.

Test Plan:
Transmitter is a stub pulsing tx_done 100 clocks after tx_start unless noted.
- Reset, NUM_REQ=4, req=4'b0100, data2=8'hA5 -> 1 clock later: tx_start=1, tx_data=A5, req_ack=4'b0100, grant_id=2, busy=1. tx_done at +100 -> req_done=4'b0100 next clock, then busy=0.
- req=4'b1111 held continuously with distinct data -> grant order 0,1,2,3,0,...; each tx_start exactly 2 clocks after the previous tx_done (GAP_CYCLES=0).
- GAP_CYCLES=5, two requesters pending -> 5 GAP clocks, then IDLE, then tx_start, i.e. 7 clocks after tx_done.
- Stub never pulses tx_done, TIMEOUT_CYCLES=64 -> timeout_err pulses 64 clocks after tx_start, no req_done, next requester granted.
- tx_done pulsed while IDLE -> no req_done, state unchanged. tx_done coinciding with the last watchdog cycle -> req_done asserted, timeout_err=0.
- reset asserted mid-WAIT_DONE, then requests resume -> all outputs 0 immediately, requester 0 granted first.
